i2c_sb_sequencer: RTL and testbench
===================================

Name: i2c_sb_sequencer

Overview:
Parametrised successor to the single-purpose i2c_sender system-bus controller. It drives the iCE40 SB_I2C hard IP system bus as an I2C master and plays a table of NUM_CMDS write transactions. Each transaction is a device address followed by BYTES_PER_CMD data bytes. It adds NACK retry, ack/poll timeouts and a start/busy/done/error handshake. It sits between board bring-up logic (sensor register init) and the SB_I2C instance; the command table is an external combinational ROM indexed by cmd_index.

Parameters:
BUS_ADDR74, 4'b0001, SB_I2C instance select; driven on sbadr[7:4] (must match the IP's BUS_ADDR74)
DEV_ADDR, 7'h3C, 7-bit I2C target address
NUM_CMDS, 16, number of table entries (>=1)
BYTES_PER_CMD, 2, data bytes per transaction (1..4)
PRESCALE, 10'd60, SB_I2C baud prescale written to I2CBRMSB/I2CBRLSB
ACK_TIMEOUT, 64, max cycles waiting for sback per bus access
POLL_LIMIT, 4096, max I2CSR reads per poll loop
MAX_RETRIES, 3, re-attempts of a NACKed transaction
CW, $clog2(NUM_CMDS) (min 1), cmd_index width (derived)

Ports:
clock  in  1  system-bus clock; the same clock feeds SB_I2C SBCLKI
reset  in  1  synchronous, active-high
start  in  1  one-cycle pulse; begins table playback (ignored while busy)
busy  out  1  high from the cycle after an accepted start until done/error asserts
done  out  1  one-cycle pulse; all NUM_CMDS transactions completed
error  out  1  one-cycle pulse; sequence aborted
err_index  out  CW  cmd_index of the failing entry; held until the next start
cmd_index  out  CW  current table entry
cmd_data  in  8*BYTES_PER_CMD  entry payload; byte 0 = [7:0], sent first
sbrw  out  1  1 = write
sbstb  out  1  strobe
sbadr  out  8  {BUS_ADDR74, reg offset}
sbdat_to_peripheral  out  8  write data
sbdat_from_peripheral  in  8  read data
sback  in  1  access acknowledge

Behaviour:
- Reset: all outputs 0; the init_done flag is cleared; the FSM enters IDLE. Reset mid-transaction aborts immediately with sbstb=0, and no STOP is issued.
- Bus access: sbadr, sbrw and sbdat are stable with sbstb=1 until the cycle sback=1 is sampled. On that cycle, read data is captured and sbstb drops for at least one cycle. If sback does not arrive within ACK_TIMEOUT cycles, the FSM goes to ERR.
- Register offsets: CR1=0x8, CMDR=0x9, BRLSB=0xA, BRMSB=0xB, SR=0xC, TXDR=0xD. SR bits: TRRDY=2, RARC=5 (1 = NACK), BUSY=6.
- FSM:
  - IDLE: on start, clear cmd_index and the retry counter. If init_done=0, go to INIT; otherwise go to ADDR.
  - INIT: write CR1=0x80, then BRLSB=PRESCALE[7:0], then BRMSB={6'b0,PRESCALE[9:8]}. Set init_done.
  - ADDR: write TXDR={DEV_ADDR,1'b0}.
  - START: write CMDR=0x94 (STA|WR|CKSDIS).
  - POLL_TX: read SR until TRRDY=1. Exceeding POLL_LIMIT reads goes to ERR.
  - CHECK: if RARC=1, go to STOP with nack flag set.
  - DATA: write TXDR=byte b, write CMDR=0x14, go to POLL_TX. Repeat for b=0..BYTES_PER_CMD-1.
  - STOP: write CMDR=0x44 (STO|CKSDIS).
  - POLL_IDLE: read SR until BUSY=0, under the same POLL_LIMIT rule.
  - NEXT, nack flag set: if retries<MAX_RETRIES, increment retries and re-run the same index from ADDR; else go to ERR.
  - NEXT, no NACK: clear retries. If cmd_index==NUM_CMDS-1, go to DONE; else increment and go to ADDR.
  - DONE: pulse done, return to IDLE.
  - ERR: latch err_index=cmd_index, pulse error, return to IDLE.
- cmd_data is sampled when each TXDR data write is launched. cmd_index is stable throughout its transaction.
- busy deasserts in the same cycle that done/error pulses.
- start while busy has no effect. start in the DONE/ERR cycle is ignored.

Test Plan:
- SB_I2C bus model acks every access in 2 cycles, TRRDY=1 and BUSY=0 immediately; NUM_CMDS=2, BYTES_PER_CMD=2 -> init writes 0x80/0x3C/0x00 to offsets 8/A/B appear once. Per entry the sequence is TXDR=0x78, CMDR=0x94, TXDR=b0, CMDR=0x14, TXDR=b1, CMDR=0x14, CMDR=0x44. done pulses once, busy low after.
- Second start after completion -> no INIT writes; the sequence begins with TXDR=0x78.
- Model returns RARC=1 on entry 1 twice, then ack -> entry 1 is sent 3 times, each aborted attempt ends with CMDR=0x44, done=1, error never asserts.
- RARC=1 always on entry 0, MAX_RETRIES=3 -> 4 attempts, error pulses, err_index=0, done never asserts.
- Model withholds sback on the 5th access -> error fires exactly ACK_TIMEOUT cycles after strobe; sbstb=0 after. A TRRDY held 0 gives error after POLL_LIMIT SR reads.
- reset asserted mid-DATA -> next cycle sbstb=0, busy=0, all outputs 0. A following start re-runs INIT.

Source files
------------

// File: rtl/i2c_sb_sequencer.sv
// Plays a table of I2C write transactions through the iCE40 SB_I2C system bus,
// with NACK retry, bus-access/poll timeouts and a start/busy/done/error handshake.
module i2c_sb_sequencer #(
    parameter logic [3:0] BUS_ADDR74    = 4'b0001,
    parameter logic [6:0] DEV_ADDR      = 7'h3C,
    parameter int         NUM_CMDS      = 16,
    parameter int         BYTES_PER_CMD = 2,
    parameter logic [9:0] PRESCALE      = 10'd60,
    parameter int         ACK_TIMEOUT   = 64,
    parameter int         POLL_LIMIT    = 4096,
    parameter int         MAX_RETRIES   = 3,
    parameter int         CW            = (NUM_CMDS > 1) ? $clog2(NUM_CMDS) : 1
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       start,
    output logic                       busy,
    output logic                       done,
    output logic                       error,
    output logic [CW-1:0]              err_index,
    output logic [CW-1:0]              cmd_index,
    input  logic [8*BYTES_PER_CMD-1:0] cmd_data,
    output logic                       sbrw,
    output logic                       sbstb,
    output logic [7:0]                 sbadr,
    output logic [7:0]                 sbdat_to_peripheral,
    input  logic [7:0]                 sbdat_from_peripheral,
    input  logic                       sback
);

    localparam int AW = $clog2(ACK_TIMEOUT + 1);
    localparam int PW = $clog2(POLL_LIMIT + 1);
    localparam int RW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

    localparam logic [AW-1:0] ACK_LAST  = AW'(ACK_TIMEOUT - 1);
    localparam logic [PW-1:0] POLL_LAST = PW'(POLL_LIMIT - 1);
    localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRIES);
    localparam logic [CW-1:0] LAST_CMD  = CW'(NUM_CMDS - 1);
    localparam logic [2:0]    NUM_BYTES = 3'(BYTES_PER_CMD);

    localparam logic [3:0] OFF_CR1   = 4'h8;
    localparam logic [3:0] OFF_CMDR  = 4'h9;
    localparam logic [3:0] OFF_BRLSB = 4'hA;
    localparam logic [3:0] OFF_BRMSB = 4'hB;
    localparam logic [3:0] OFF_SR    = 4'hC;
    localparam logic [3:0] OFF_TXDR  = 4'hD;

    localparam int SR_TRRDY = 2;
    localparam int SR_RARC  = 5;
    localparam int SR_BUSY  = 6;

    localparam logic [3:0] S_IDLE      = 4'd0;
    localparam logic [3:0] S_INIT_CR1  = 4'd1;
    localparam logic [3:0] S_INIT_BRL  = 4'd2;
    localparam logic [3:0] S_INIT_BRM  = 4'd3;
    localparam logic [3:0] S_ADDR      = 4'd4;
    localparam logic [3:0] S_START     = 4'd5;
    localparam logic [3:0] S_POLL_TX   = 4'd6;
    localparam logic [3:0] S_CHECK     = 4'd7;
    localparam logic [3:0] S_DATA_TX   = 4'd8;
    localparam logic [3:0] S_DATA_CMD  = 4'd9;
    localparam logic [3:0] S_STOP      = 4'd10;
    localparam logic [3:0] S_POLL_IDLE = 4'd11;
    localparam logic [3:0] S_NEXT      = 4'd12;
    localparam logic [3:0] S_DONE      = 4'd13;
    localparam logic [3:0] S_ERR       = 4'd14;

    logic [3:0]    state;
    logic          init_done;
    logic          nack;
    logic [RW-1:0] retries;
    logic [2:0]    byte_idx;
    logic [AW-1:0] ack_cnt;
    logic [PW-1:0] poll_cnt;
    logic [7:0]    sr_q;

    logic [3:0]    acc_off;
    logic          acc_rw;
    logic [7:0]    acc_dat;
    logic [7:0]    tx_byte;
    logic          poll_ok;
    logic          unused_sr;

    assign busy  = (state != S_IDLE) && (state != S_DONE) && (state != S_ERR);
    assign done  = (state == S_DONE);
    assign error = (state == S_ERR);

    assign unused_sr = ^{sr_q[7:6], sr_q[4:0]};

    assign poll_ok = (state == S_POLL_TX) ? sbdat_from_peripheral[SR_TRRDY]
                                          : !sbdat_from_peripheral[SR_BUSY];

    always_comb begin
        tx_byte = '0;
        for (int unsigned b = 0; b < BYTES_PER_CMD; b++) begin
            if (byte_idx == 3'(b)) tx_byte = cmd_data[8*b +: 8];
        end
    end

    // Register offset, direction and write data for the access each bus state performs
    always_comb begin
        acc_off = OFF_SR;
        acc_rw  = 1'b0;
        acc_dat = '0;
        case (state)
            S_INIT_CR1: begin acc_off = OFF_CR1;   acc_rw = 1'b1; acc_dat = 8'h80; end
            S_INIT_BRL: begin acc_off = OFF_BRLSB; acc_rw = 1'b1; acc_dat = PRESCALE[7:0]; end
            S_INIT_BRM: begin acc_off = OFF_BRMSB; acc_rw = 1'b1; acc_dat = {6'b0, PRESCALE[9:8]}; end
            S_ADDR:     begin acc_off = OFF_TXDR;  acc_rw = 1'b1; acc_dat = {DEV_ADDR, 1'b0}; end
            S_START:    begin acc_off = OFF_CMDR;  acc_rw = 1'b1; acc_dat = 8'h94; end
            S_DATA_TX:  begin acc_off = OFF_TXDR;  acc_rw = 1'b1; acc_dat = tx_byte; end
            S_DATA_CMD: begin acc_off = OFF_CMDR;  acc_rw = 1'b1; acc_dat = 8'h14; end
            S_STOP:     begin acc_off = OFF_CMDR;  acc_rw = 1'b1; acc_dat = 8'h44; end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state               <= S_IDLE;
            init_done           <= 1'b0;
            nack                <= 1'b0;
            retries             <= '0;
            byte_idx            <= '0;
            ack_cnt             <= '0;
            poll_cnt            <= '0;
            sr_q                <= '0;
            cmd_index           <= '0;
            err_index           <= '0;
            sbstb               <= 1'b0;
            sbrw                <= 1'b0;
            sbadr               <= '0;
            sbdat_to_peripheral <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        cmd_index <= '0;
                        err_index <= '0;
                        retries   <= '0;
                        nack      <= 1'b0;
                        byte_idx  <= '0;
                        poll_cnt  <= '0;
                        state     <= init_done ? S_ADDR : S_INIT_CR1;
                    end
                end
                S_CHECK: begin
                    if (sr_q[SR_RARC]) begin
                        nack  <= 1'b1;
                        state <= S_STOP;
                    end else if (byte_idx == NUM_BYTES) begin
                        state <= S_STOP;
                    end else begin
                        state <= S_DATA_TX;
                    end
                end
                S_NEXT: begin
                    if (nack) begin
                        nack <= 1'b0;
                        if (retries < RETRY_MAX) begin
                            retries <= retries + RW'(1);
                            state   <= S_ADDR;
                        end else begin
                            err_index <= cmd_index;
                            state     <= S_ERR;
                        end
                    end else begin
                        retries <= '0;
                        if (cmd_index == LAST_CMD) begin
                            state <= S_DONE;
                        end else begin
                            cmd_index <= cmd_index + CW'(1);
                            state     <= S_ADDR;
                        end
                    end
                end
                S_DONE, S_ERR: state <= S_IDLE;
                S_INIT_CR1, S_INIT_BRL, S_INIT_BRM, S_ADDR, S_START, S_POLL_TX,
                S_DATA_TX, S_DATA_CMD, S_STOP, S_POLL_IDLE: begin
                    // Launch with sbstb low, hold until sback, then drop sbstb for one cycle
                    if (!sbstb) begin
                        sbstb               <= 1'b1;
                        sbadr               <= {BUS_ADDR74, acc_off};
                        sbrw                <= acc_rw;
                        sbdat_to_peripheral <= acc_dat;
                        ack_cnt             <= '0;
                    end else if (sback) begin
                        sbstb <= 1'b0;
                        sr_q  <= sbdat_from_peripheral;
                        case (state)
                            S_INIT_CR1: state <= S_INIT_BRL;
                            S_INIT_BRL: state <= S_INIT_BRM;
                            S_INIT_BRM: begin
                                init_done <= 1'b1;
                                state     <= S_ADDR;
                            end
                            S_ADDR:  state <= S_START;
                            S_START: begin
                                byte_idx <= '0;
                                state    <= S_POLL_TX;
                            end
                            S_DATA_TX:  state <= S_DATA_CMD;
                            S_DATA_CMD: begin
                                byte_idx <= byte_idx + 3'd1;
                                state    <= S_POLL_TX;
                            end
                            S_STOP: state <= S_POLL_IDLE;
                            S_POLL_TX, S_POLL_IDLE: begin
                                if (poll_ok) begin
                                    poll_cnt <= '0;
                                    state    <= (state == S_POLL_TX) ? S_CHECK : S_NEXT;
                                end else if (poll_cnt == POLL_LAST) begin
                                    err_index <= cmd_index;
                                    state     <= S_ERR;
                                end else begin
                                    poll_cnt <= poll_cnt + PW'(1);
                                end
                            end
                            default: state <= S_IDLE;
                        endcase
                    end else if (ack_cnt == ACK_LAST) begin
                        sbstb     <= 1'b0;
                        err_index <= cmd_index;
                        state     <= S_ERR;
                    end else begin
                        ack_cnt <= ack_cnt + AW'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_sb_sequencer.sv
// Bench for i2c_sb_sequencer: SB_I2C bus responder plus a transaction-list
// reference model built from the table contents and the NACK plan.
module tb_i2c_sb_sequencer;

    localparam int NC       = 2;
    localparam int NB       = 2;
    localparam int ACK_TO   = 16;
    localparam int POLL_LIM = 8;
    localparam int MAX_RT   = 3;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        busy, done, error;
    logic [0:0]  err_index, cmd_index;
    logic [15:0] cmd_data;
    logic        sbrw, sbstb;
    logic [7:0]  sbadr, sbdat_to, sbdat_from;
    logic        sback;

    logic [15:0] rom [NC];
    assign cmd_data = rom[cmd_index];

    i2c_sb_sequencer #(
        .NUM_CMDS      (NC),
        .BYTES_PER_CMD (NB),
        .ACK_TIMEOUT   (ACK_TO),
        .POLL_LIMIT    (POLL_LIM),
        .MAX_RETRIES   (MAX_RT)
    ) dut (
        .clock                 (clock),
        .reset                 (reset),
        .start                 (start),
        .busy                  (busy),
        .done                  (done),
        .error                 (error),
        .err_index             (err_index),
        .cmd_index             (cmd_index),
        .cmd_data              (cmd_data),
        .sbrw                  (sbrw),
        .sbstb                 (sbstb),
        .sbadr                 (sbadr),
        .sbdat_to_peripheral   (sbdat_to),
        .sbdat_from_peripheral (sbdat_from),
        .sback                 (sback)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // Bus responder knobs (written by the stimulus only)
    int withhold_at = 0;
    bit trrdy_stuck = 1'b0;
    int nack_entry  = -1;
    int nack_budget = 0;
    bit model_clear = 1'b0;

    // Bus responder state
    logic        in_acc = 1'b0, hold = 1'b0, nacking = 1'b0, in_txn = 1'b0;
    int          acc_num = 0, sr_reads = 0, nack_seen = 0, log_n = 0;
    logic [15:0] log_mem [1024];

    always @(posedge clock) begin
        if (reset) begin
            sback      <= 1'b0;
            in_acc     <= 1'b0;
            hold       <= 1'b0;
            nacking    <= 1'b0;
            in_txn     <= 1'b0;
            sbdat_from <= '0;
        end else if (sback) begin
            sback  <= 1'b0;
            in_acc <= 1'b0;
            if (sbrw) begin
                log_mem[log_n] <= {sbadr, sbdat_to};
                log_n <= log_n + 1;
                if (sbadr[3:0] == 4'hD && !in_txn) begin
                    in_txn <= 1'b1;
                    if (int'(cmd_index) == nack_entry && nack_seen < nack_budget) begin
                        nacking   <= 1'b1;
                        nack_seen <= nack_seen + 1;
                    end
                end
                if (sbadr[3:0] == 4'h9 && sbdat_to == 8'h44) begin
                    nacking <= 1'b0;
                    in_txn  <= 1'b0;
                end
            end else begin
                sr_reads <= sr_reads + 1;
            end
        end else if (sbstb && !in_acc) begin
            in_acc  <= 1'b1;
            acc_num <= acc_num + 1;
            hold    <= (acc_num + 1 == withhold_at);
        end else if (sbstb && !hold) begin
            sback      <= 1'b1;
            sbdat_from <= {1'b0, 1'b0, nacking, 1'b0, 1'b0, !trrdy_stuck, 2'b00};
        end else if (!sbstb) begin
            in_acc <= 1'b0;
            hold   <= 1'b0;
        end
        if (model_clear) begin
            nack_seen <= 0;
            nacking   <= 1'b0;
            in_txn    <= 1'b0;
        end
    end

    int n_cmp = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: expected write list {sbadr, data} for one playback
    logic [15:0] exp_q [$];
    bit          exp_err;
    int          exp_err_idx;

    task automatic build_exp(input bit with_init, input int nk_entry, input int nk);
        int k, fails;
        exp_q.delete();
        exp_err = 1'b0;
        exp_err_idx = 0;
        if (with_init) begin
            exp_q.push_back(16'h1880);
            exp_q.push_back(16'h1A3C);
            exp_q.push_back(16'h1B00);
        end
        for (int e = 0; e < NC; e++) begin
            k = (e == nk_entry) ? nk : 0;
            fails = (k > MAX_RT) ? MAX_RT + 1 : k;
            for (int a = 0; a < fails; a++) begin
                exp_q.push_back(16'h1D78);
                exp_q.push_back(16'h1994);
                exp_q.push_back(16'h1944);
            end
            if (k > MAX_RT) begin
                exp_err = 1'b1;
                exp_err_idx = e;
                return;
            end
            exp_q.push_back(16'h1D78);
            exp_q.push_back(16'h1994);
            for (int b = 0; b < NB; b++) begin
                exp_q.push_back({8'h1D, rom[e][8*b +: 8]});
                exp_q.push_back(16'h1914);
            end
            exp_q.push_back(16'h1944);
        end
    endtask

    task automatic compare_log(input string tag, input int base);
        check({tag, "_len"}, log_n - base, exp_q.size());
        for (int i = 0; i < exp_q.size() && base + i < log_n; i++)
            check($sformatf("%s[%0d]", tag, i), log_mem[base + i], exp_q[i]);
    endtask

    task automatic pulse_start();
        @(negedge clock);
        start = 1'b1;
        model_clear = 1'b1;
        @(negedge clock);
        start = 1'b0;
        model_clear = 1'b0;
    endtask

    int         done_cnt, err_cnt, extra_pulses, fin_cyc, last_rise;
    logic       fin_busy, fin_stb;
    logic [7:0] fin_sbadr;
    logic [0:0] fin_err_index;

    task automatic wait_end(input int budget, input bit start_on_end);
        logic prev;
        int   n;
        prev = sbstb;
        n = 0;
        done_cnt = 0;
        err_cnt = 0;
        extra_pulses = 0;
        while (n < budget && !(done || error)) begin
            @(negedge clock);
            n++;
            if (sbstb && !prev) last_rise = cyc;
            prev = sbstb;
        end
        check("end_reached", {31'd0, done || error}, 1);
        done_cnt      = int'(done);
        err_cnt       = int'(error);
        fin_busy      = busy;
        fin_stb       = sbstb;
        fin_sbadr     = sbadr;
        fin_cyc       = cyc;
        fin_err_index = err_index;
        if (start_on_end) start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        if (start_on_end) check("start_in_end_cycle_busy", busy, 0);
        repeat (6) begin
            extra_pulses += int'(done) + int'(error);
            @(negedge clock);
        end
    endtask

    initial begin
        int base, snap, txdr_rises;
        logic prev;

        for (int e = 0; e < NC; e++) rom[e] = 16'($urandom);
        repeat (3) @(negedge clock);
        check("reset_outputs", {busy, done, error, sbstb, sbrw, sbadr, sbdat_to, cmd_index, err_index}, 0);
        reset = 1'b0;
        @(negedge clock);
        check("idle_outputs", {busy, done, error, sbstb}, 0);

        // Run 1: first playback includes the init writes
        base = log_n;
        build_exp(1'b1, -1, 0);
        pulse_start();
        check("busy_after_start", busy, 1);
        wait_end(2000, 1'b0);
        check("run1_done", done_cnt, 1);
        check("run1_error", err_cnt, 0);
        check("run1_busy_at_done", fin_busy, 0);
        check("run1_extra_pulses", extra_pulses, 0);
        check("run1_busy_after", busy, 0);
        compare_log("run1_log", base);

        // Run 2: no init, start while busy and start in the DONE cycle ignored
        for (int e = 0; e < NC; e++) rom[e] = 16'($urandom);
        base = log_n;
        build_exp(1'b0, -1, 0);
        pulse_start();
        repeat (10) @(negedge clock);
        check("run2_busy_mid", busy, 1);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        wait_end(2000, 1'b1);
        check("run2_done", done_cnt, 1);
        check("run2_extra_pulses", extra_pulses, 0);
        compare_log("run2_log", base);

        // Run 3: entry 1 NACKed twice, then accepted
        for (int e = 0; e < NC; e++) rom[e] = 16'($urandom);
        nack_entry = 1;
        nack_budget = 2;
        base = log_n;
        build_exp(1'b0, 1, 2);
        pulse_start();
        wait_end(2000, 1'b0);
        check("run3_done", done_cnt, 1);
        check("run3_error", err_cnt + extra_pulses, 0);
        compare_log("run3_log", base);

        // Runs 4 and 5: persistent NACK exhausts retries on entry 0, then entry 1
        for (int ent = 0; ent < NC; ent++) begin
            nack_entry = ent;
            nack_budget = 100;
            base = log_n;
            build_exp(1'b0, ent, 100);
            pulse_start();
            wait_end(2000, 1'b0);
            check($sformatf("nackall%0d_error", ent), err_cnt, {31'd0, exp_err});
            check($sformatf("nackall%0d_done", ent), done_cnt + extra_pulses, 0);
            check($sformatf("nackall%0d_err_index", ent), fin_err_index, exp_err_idx);
            check($sformatf("nackall%0d_busy_at_err", ent), fin_busy, 0);
            compare_log($sformatf("nackall%0d_log", ent), base);
        end
        nack_entry = -1;
        nack_budget = 0;

        // Run 6: 5th access after reset never acknowledged
        @(negedge clock);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        withhold_at = acc_num + 5;
        pulse_start();
        wait_end(2000, 1'b0);
        withhold_at = 0;
        check("ackto_error", err_cnt, 1);
        check("ackto_latency", fin_cyc - last_rise, ACK_TO);
        check("ackto_access_is_cmdr", fin_sbadr, 8'h19);
        check("ackto_sbstb_low", fin_stb, 0);
        check("ackto_done", done_cnt + extra_pulses, 0);

        // Run 7: TRRDY never set
        trrdy_stuck = 1'b1;
        snap = sr_reads;
        pulse_start();
        wait_end(2000, 1'b0);
        trrdy_stuck = 1'b0;
        check("poll_error", err_cnt, 1);
        check("poll_sr_reads", sr_reads - snap, POLL_LIM);
        check("poll_err_index", fin_err_index, 0);

        // Run 8: reset during the first data-byte TXDR write, then full replay
        for (int e = 0; e < NC; e++) rom[e] = 16'($urandom);
        pulse_start();
        txdr_rises = 0;
        prev = sbstb;
        for (int n = 0; n < 2000 && txdr_rises < 2; n++) begin
            @(negedge clock);
            if (sbstb && !prev && sbadr == 8'h1D) txdr_rises++;
            prev = sbstb;
        end
        check("mid_data_reached", txdr_rises, 2);
        reset = 1'b1;
        @(negedge clock);
        check("mid_reset_outputs", {busy, done, error, sbstb, sbrw, sbadr, sbdat_to, cmd_index, err_index}, 0);
        reset = 1'b0;
        @(negedge clock);
        base = log_n;
        build_exp(1'b1, -1, 0);
        pulse_start();
        wait_end(2000, 1'b0);
        check("rerun_done", done_cnt, 1);
        compare_log("rerun_log", base);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
